mem_arbiter: RTL

- Shares the single external DRAM burst port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs).
- Sits between both caches and the DRAM model/controller.
- Grants one full BLOCK_SIZE-beat burst at a time, with round-robin arbitration.
- Steers beat-valid strobes to the owning cache only.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one DRAM burst port between icache and dcache
module mem_arbiter #(
    parameter int BLOCK_SIZE = 8,
    parameter int OFFSET_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_val,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_data,
    output logic        d_val,
    output logic        d_wnext,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_val,
    output logic [1:0]  owner
);

    localparam int CNT_W = $clog2(BLOCK_SIZE);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               last_d_q, last_d_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [1:0]         owner_q, owner_d;

    logic               any_req;
    logic               pick_d;
    logic               in_grant;
    logic               last_beat;
    logic               unused_addr_bits;

    // On a tie the client that did not win last time gets the port
    assign any_req   = i_req | d_req;
    assign pick_d    = d_req & (~i_req | ~last_d_q);
    assign in_grant  = (state_q == GNT_I) || (state_q == GNT_D);
    assign last_beat = in_grant && mem_val && (beat_cnt_q == CNT_W'(BLOCK_SIZE - 1));
    assign unused_addr_bits = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            last_d_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            owner_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_d_q   <= last_d_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            owner_q    <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (any_req) state_d = pick_d ? GNT_D : GNT_I;
            GNT_I, GNT_D: if (last_beat) state_d = DONE;
            DONE:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        last_d_d   = last_d_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        owner_d    = owner_q;
        if (state_q == IDLE && any_req) begin
            beat_cnt_d = '0;
            last_d_d   = pick_d;
            mem_req_d  = 1'b1;
            if (pick_d) begin
                mem_addr_d = {d_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                mem_we_d   = d_we;
                owner_d    = 2'b10;
            end else begin
                mem_addr_d = {i_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                mem_we_d   = 1'b0;
                owner_d    = 2'b01;
            end
        end else if (in_grant && mem_val) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (last_beat) begin
                mem_req_d = 1'b0;
                owner_d   = 2'b00;
            end
        end
    end

    always_comb begin
        i_val     = mem_val & (state_q == GNT_I);
        d_val     = mem_val & (state_q == GNT_D) & ~mem_we_q;
        d_wnext   = mem_val & (state_q == GNT_D) & mem_we_q;
        i_data    = mem_rdata;
        d_data    = mem_rdata;
        mem_wdata = d_wdata;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        owner     = owner_q;
    end

endmodule
